// File: rtl/gate_bus_pkg.sv
// Shared constants for the gate_bus_pipe block: reduction mode encodings
// and the width of the output transfer counter.
package gate_bus_pkg;

    localparam logic [1:0] GATE_MODE_AND  = 2'd0;
    localparam logic [1:0] GATE_MODE_OR   = 2'd1;
    localparam logic [1:0] GATE_MODE_XOR  = 2'd2;
    localparam logic [1:0] GATE_MODE_NAND = 2'd3;

    localparam int XFER_COUNT_W = 16;

endpackage

// File: rtl/gate_bus_pipe_if.sv
// Operand/result handshake bundle of gate_bus_pipe.
// The slave modport is the pipe itself; the master modport is the
// producer/consumer pair that surrounds it.
interface gate_bus_pipe_if #(
    parameter int NrOfBits   = 1,
    parameter int NrOfInputs = 2
) ();
    import gate_bus_pkg::*;

    logic [NrOfInputs*NrOfBits-1:0] Inputs;
    logic [1:0]                     Mode;
    logic                           InValid;
    logic                           InReady;
    logic [NrOfBits-1:0]            Result;
    logic                           ResultZero;
    logic                           ResultOnes;
    logic                           OutValid;
    logic                           OutReady;
    logic [XFER_COUNT_W-1:0]        XferCount;

    modport master (
        output Inputs, Mode, InValid, OutReady,
        input  InReady, Result, ResultZero, ResultOnes, OutValid, XferCount
    );

    modport slave (
        input  Inputs, Mode, InValid, OutReady,
        output InReady, Result, ResultZero, ResultOnes, OutValid, XferCount
    );

endinterface

// File: rtl/gate_bus_stage.sv
// Generic valid/ready register stage without a skid buffer. Ready is
// passed backward combinationally: the stage can take new data when it
// is empty or when its current contents leave in the same cycle.
module gate_bus_stage #(
    parameter int PayloadWidth = 1
) (
    input  logic                    Clock,
    input  logic                    Reset,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [PayloadWidth-1:0] in_data,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [PayloadWidth-1:0] out_data
);

    logic                    valid_q;
    logic [PayloadWidth-1:0] data_q;

    assign in_ready  = !valid_q || out_ready;
    assign out_valid = valid_q;
    assign out_data  = data_q;

    // Load on input fire; otherwise drop valid once the consumer takes the data.
    always_ff @(posedge Clock) begin
        if (Reset) begin
            valid_q <= 1'b0;
            // NOTE: the payload is reset too, because the result and flags must read zero after reset.
            data_q  <= '0;
        end else if (in_valid && in_ready) begin
            valid_q <= 1'b1;
            data_q  <= in_data;
        end else if (out_ready) begin
            valid_q <= 1'b0;
        end
    end

endmodule

// File: rtl/gate_bus_pipe.sv
// gate_bus_pipe: pipelined N-input bus gate with per-input bubbles and a
// run-time selectable AND/OR/XOR/NAND reduction behind valid/ready.
// Build option GATE_BUS_PIPE_INREG_EN adds an operand register stage in
// front of the result stage (latency 2, capacity 2); without it the
// bubbles and reduction feed the result stage directly (latency 1).
module gate_bus_pipe
    import gate_bus_pkg::*;
#(
    parameter int                    NrOfBits    = 1,
    parameter int                    NrOfInputs  = 2,
    parameter logic [NrOfInputs-1:0] BubblesMask = '0
) (
    input logic            Clock,
    input logic            Reset,
    gate_bus_pipe_if.slave bus
);

    localparam int OpsWidth = NrOfInputs * NrOfBits;
    localparam int ResWidth = NrOfBits + 2;

    // Reduce all operands with the selected bitwise function.
    function automatic logic [NrOfBits-1:0] reduce_ops(
        input logic [OpsWidth-1:0] ops,
        input logic [1:0]          mode
    );
        logic [NrOfBits-1:0] acc_and;
        logic [NrOfBits-1:0] acc_or;
        logic [NrOfBits-1:0] acc_xor;
        logic [NrOfBits-1:0] res;
        acc_and = '1;
        acc_or  = '0;
        acc_xor = '0;
        for (int i = 0; i < NrOfInputs; i++) begin
            acc_and = acc_and & ops[i*NrOfBits +: NrOfBits];
            acc_or  = acc_or  | ops[i*NrOfBits +: NrOfBits];
            acc_xor = acc_xor ^ ops[i*NrOfBits +: NrOfBits];
        end
        case (mode)
            GATE_MODE_AND:  res = acc_and;
            GATE_MODE_OR:   res = acc_or;
            GATE_MODE_XOR:  res = acc_xor;
            GATE_MODE_NAND: res = ~acc_and;
            default:        res = acc_and;
        endcase
        return res;
    endfunction

    logic [OpsWidth-1:0] ops_bubbled;

    // Invert each operand whose bubble bit is set.
    always_comb begin
        // NOTE: every bit gets a value on every pass, so no latch is inferred.
        ops_bubbled = bus.Inputs;
        for (int i = 0; i < NrOfInputs; i++) begin
            if (BubblesMask[i]) begin
                ops_bubbled[i*NrOfBits +: NrOfBits] = ~bus.Inputs[i*NrOfBits +: NrOfBits];
            end
        end
    end

    // Reduction-stage inputs, either straight from the bus or from the operand register.
    logic [OpsWidth-1:0] red_ops;
    logic [1:0]          red_mode;
    logic                red_valid;
    logic                red_ready;
    logic                in_ready;

`ifdef GATE_BUS_PIPE_INREG_EN
    logic [OpsWidth+1:0] op_payload;

    gate_bus_stage #(
        .PayloadWidth(OpsWidth + 2)
    ) u_op_stage (
        .Clock     (Clock),
        .Reset     (Reset),
        .in_valid  (bus.InValid),
        .in_ready  (in_ready),
        .in_data   ({bus.Mode, ops_bubbled}),
        .out_valid (red_valid),
        .out_ready (red_ready),
        .out_data  (op_payload)
    );

    assign red_ops  = op_payload[OpsWidth-1:0];
    assign red_mode = op_payload[OpsWidth+1:OpsWidth];
`else
    assign red_ops   = ops_bubbled;
    assign red_mode  = bus.Mode;
    assign red_valid = bus.InValid;
    assign in_ready  = red_ready;
`endif

    logic [NrOfBits-1:0] red_result;
    logic [ResWidth-1:0] res_payload;
    logic                out_valid;

    assign red_result = reduce_ops(red_ops, red_mode);

    gate_bus_stage #(
        .PayloadWidth(ResWidth)
    ) u_res_stage (
        .Clock     (Clock),
        .Reset     (Reset),
        .in_valid  (red_valid),
        .in_ready  (red_ready),
        .in_data   ({(red_result == '1), (red_result == '0), red_result}),
        .out_valid (out_valid),
        .out_ready (bus.OutReady),
        .out_data  (res_payload)
    );

    logic [XFER_COUNT_W-1:0] xfer_count;

    // Count completed output transfers; wraps naturally at the counter width.
    always_ff @(posedge Clock) begin
        if (Reset) begin
            xfer_count <= '0;
        end else if (out_valid && bus.OutReady) begin
            xfer_count <= xfer_count + XFER_COUNT_W'(1);
        end
    end

    assign bus.InReady    = in_ready;
    assign bus.OutValid   = out_valid;
    assign bus.Result     = res_payload[NrOfBits-1:0];
    assign bus.ResultZero = res_payload[NrOfBits];
    assign bus.ResultOnes = res_payload[NrOfBits+1];
    assign bus.XferCount  = xfer_count;

endmodule

// File: tb/tb_gate_bus_pipe.sv
// Self-checking bench for gate_bus_pipe (NrOfBits=8, NrOfInputs=3,
// BubblesMask=3'b010). Stimulus pushes hand-computed expected results into
// a queue; a monitor pops and compares on every output transfer.
module tb_gate_bus_pipe;

`ifdef GATE_BUS_PIPE_INREG_EN
    localparam int LAT = 2;
`else
    localparam int LAT = 1;
`endif
    localparam int CAP = LAT;

    typedef struct packed {
        logic [7:0] res;
        logic       zero;
        logic       ones;
    } exp_t;

    logic Clock;
    logic Reset;

    gate_bus_pipe_if #(.NrOfBits(8), .NrOfInputs(3)) bus ();

    gate_bus_pipe #(
        .NrOfBits    (8),
        .NrOfInputs  (3),
        .BubblesMask (3'b010)
    ) dut (
        .Clock (Clock),
        .Reset (Reset),
        .bus   (bus)
    );

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    int   n_checks = 0;
    int   n_pass   = 0;
    exp_t exp_q[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act === req) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, req);
    endtask

    // Monitor: compare every output transfer against the queue and check hold stability.
    logic       prev_stall = 1'b0;
    logic [7:0] held_res   = 8'h00;
    always @(negedge Clock) begin
        if (Reset) begin
            prev_stall = 1'b0;
        end else begin
            if (prev_stall) check("hold_stable", {23'd0, bus.OutValid, bus.Result}, {23'd0, 1'b1, held_res});
            if (bus.OutValid && bus.OutReady) begin
                if (exp_q.size() == 0) begin
                    check("pending_count", exp_q.size(), 1);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    check("out", {22'd0, bus.Result, bus.ResultZero, bus.ResultOnes}, {22'd0, e});
                end
            end
            prev_stall = bus.OutValid && !bus.OutReady;
            held_res   = bus.Result;
        end
    end

    // Present one transfer and wait (bounded) until it is accepted; called at posedge+1.
    task automatic send(input logic [7:0] o2, input logic [7:0] o1, input logic [7:0] o0,
                        input logic [1:0] m, input logic [7:0] er, output int stalls);
        logic rdy;
        logic done;
        exp_t e;
        bus.Inputs  = {o2, o1, o0};
        bus.Mode    = m;
        bus.InValid = 1'b1;
        stalls = 0;
        done   = 1'b0;
        for (int i = 0; i < 100 && !done; i++) begin
            @(negedge Clock);
            rdy = bus.InReady;
            @(posedge Clock);
            #1;
            if (rdy) begin
                e.res  = er;
                e.zero = (er == 8'h00);
                e.ones = (er == 8'hFF);
                exp_q.push_back(e);
                done = 1'b1;
            end else begin
                stalls++;
            end
        end
        if (!done) check("accept_timeout", 0, 1);
        bus.InValid = 1'b0;
    endtask

    // Wait (bounded) until every expected result has left the pipe.
    task automatic drain();
        for (int i = 0; i < 50 && exp_q.size() != 0; i++) @(posedge Clock);
        @(posedge Clock);
        #1;
        check("drain_empty", exp_q.size(), 0);
    endtask

    logic [7:0] bp_o2[3]  = '{8'h3C, 8'h3C, 8'h3C};
    logic [7:0] bp_o0[3]  = '{8'hA5, 8'hA5, 8'hA5};
    logic [1:0] bp_m[3]   = '{2'd0, 2'd2, 2'd1};
    logic [7:0] bp_exp[3] = '{8'h24, 8'h66, 8'hFF};

    initial begin
        int st;
        int st_sum;
        int k;
        logic r;
        logic [15:0] cnt0;

        Reset        = 1'b1;
        bus.Inputs   = '0;
        bus.Mode     = 2'd0;
        bus.InValid  = 1'b0;
        bus.OutReady = 1'b1;
        repeat (2) @(posedge Clock);
        #1;
        Reset = 1'b0;

        // Reset state.
        check("rst_outvalid", bus.OutValid, 0);
        check("rst_result", bus.Result, 0);
        check("rst_zero", bus.ResultZero, 0);
        check("rst_ones", bus.ResultOnes, 0);
        check("rst_xfercount", bus.XferCount, 0);
        check("rst_inready", bus.InReady, 1);

        // AND with bubble: 0xFF & ~0x0F & 0xF0 = 0xF0, latency check.
        send(8'hFF, 8'h0F, 8'hF0, 2'd0, 8'hF0, st);
        repeat (LAT - 1) begin
            @(posedge Clock);
            #1;
        end
        check("and_latency_valid", bus.OutValid, 1);
        check("and_result", bus.Result, 8'hF0);
        drain();
        check("and_xfercount", bus.XferCount, 1);

        // All four modes back to back; all operands are zero after the bubble.
        st_sum = 0;
        send(8'h00, 8'hFF, 8'h00, 2'd0, 8'h00, st); st_sum += st;
        send(8'h00, 8'hFF, 8'h00, 2'd1, 8'h00, st); st_sum += st;
        send(8'h00, 8'hFF, 8'h00, 2'd2, 8'h00, st); st_sum += st;
        send(8'h00, 8'hFF, 8'h00, 2'd3, 8'hFF, st); st_sum += st;
        check("modes_no_stall", st_sum, 0);
        drain();
        check("modes_xfercount", bus.XferCount, 5);

        // Backpressure: three transfers while the consumer is stalled.
        bus.OutReady = 1'b0;
        k = 0;
        for (int c = 0; c < 5; c++) begin
            if (k < 3) begin
                bus.Inputs  = {bp_o2[k], 8'h00, bp_o0[k]};
                bus.Mode    = bp_m[k];
                bus.InValid = 1'b1;
            end else begin
                bus.InValid = 1'b0;
            end
            @(negedge Clock);
            r = bus.InReady;
            @(posedge Clock);
            #1;
            if (r && k < 3) begin
                exp_t e;
                e.res  = bp_exp[k];
                e.zero = (bp_exp[k] == 8'h00);
                e.ones = (bp_exp[k] == 8'hFF);
                exp_q.push_back(e);
                k++;
            end
        end
        check("bp_accepted", k, CAP);
        check("bp_inready_low", bus.InReady, 0);
        check("bp_result_head", bus.Result, 8'h24);
        bus.OutReady = 1'b1;
        while (k < 3) begin
            send(bp_o2[k], 8'h00, bp_o0[k], bp_m[k], bp_exp[k], st);
            k++;
        end
        drain();
        check("bp_xfercount", bus.XferCount, 8);

        // Simultaneous fire: 10 back-to-back XOR transfers, result = i.
        cnt0 = bus.XferCount;
        st_sum = 0;
        for (int i = 1; i <= 10; i++) begin
            send(8'(i), 8'hFF, 8'h00, 2'd2, 8'(i), st);
            st_sum += st;
        end
        check("simul_no_stall", st_sum, 0);
        drain();
        check("simul_xfer_delta", 16'(bus.XferCount - cnt0), 10);

        // Reset mid-flight, with a transfer offered during the reset cycle.
        bus.OutReady = 1'b0;
        send(8'h3C, 8'h00, 8'hA5, 2'd0, 8'h24, st);
        bus.Inputs  = {8'hFF, 8'h00, 8'hFF};
        bus.Mode    = 2'd1;
        bus.InValid = 1'b1;
        Reset       = 1'b1;
        exp_q.delete();
        @(posedge Clock);
        #1;
        Reset        = 1'b0;
        bus.InValid  = 1'b0;
        bus.OutReady = 1'b1;
        check("mid_rst_outvalid", bus.OutValid, 0);
        check("mid_rst_result", bus.Result, 0);
        check("mid_rst_xfercount", bus.XferCount, 0);
        check("mid_rst_inready", bus.InReady, 1);
        repeat (LAT) @(posedge Clock);
        #1;
        check("mid_rst_not_accepted", bus.OutValid, 0);

        // Counter wrap: 65535 fires reach 0xFFFF, one more wraps to 0.
        for (int i = 0; i < 65535; i++) send(8'h00, 8'hFF, 8'h00, 2'd0, 8'h00, st);
        drain();
        check("wrap_ffff", bus.XferCount, 16'hFFFF);
        send(8'h00, 8'hFF, 8'h00, 2'd0, 8'h00, st);
        drain();
        check("wrap_zero", bus.XferCount, 16'h0000);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
